mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, data path and ALU result width.
REQ-002 Parameter DADDR_W, default 8, data-memory word-address width.
REQ-003 Parameter RF_AW, default 4, register-file destination address width.
REQ-004 Parameter PC_W, default 5, program counter width.
REQ-005 Parameter TIMEOUT_CYC, default 15, maximum WAIT cycles before a load aborts; legal range 1..255.
REQ-006 Port clk, input, 1, the single clock; rst, input, 1, reset, synchronous and active-high.
REQ-007 Ports in_valid (in, 1), in_ready (out, 1): upstream instruction handshake.
REQ-008 Ports opcode (in, 5), isimm (in, 1), aluout (in, DATA_W), store_data (in, DATA_W), dest_addr (in, RF_AW), pc (in, PC_W): upstream instruction fields.
REQ-009 Ports dmem_req, dmem_we (out, 1), dmem_addr (out, DADDR_W), dmem_wdata (out, DATA_W), dmem_be (out, DATA_W/8), dmem_gnt (in, 1): memory request channel.
REQ-010 Ports dmem_rvalid (in, 1), dmem_rdata (in, DATA_W): memory read-response channel.
REQ-011 Ports out_valid, wb_en, err (out, 1), wb_data (out, DATA_W), opcode_out (out, 5), dest_out (out, RF_AW), pc_out (out, PC_W): registered writeback-stage outputs.

Function
REQ-012 An instruction is accepted on a rising clk edge when in_valid && in_ready; in_ready = (state == IDLE) && !rst.
REQ-013 FSM states IDLE, REQ, WAIT; each accepted instruction produces exactly one out_valid pulse, never zero or two.
REQ-014 Opcodes NOP..ARSH, and any opcode with isimm=1: one-cycle latency; out_valid=1, wb_en=1 (0 for NOP), wb_data=aluout; FSM stays IDLE.
REQ-015 LDW or STR with isimm=0: IDLE->REQ; dmem_addr=aluout[DADDR_W-1:0], dmem_we=1 for STR, dmem_wdata=store_data; request held stable until dmem_gnt.
REQ-016 STR: REQ->IDLE on dmem_gnt; next cycle out_valid=1, wb_en=0.
REQ-017 LDW: REQ->WAIT on dmem_gnt; dmem_rvalid in the gnt cycle completes directly to IDLE with no WAIT cycle.
REQ-018 LDW completion: cycle after dmem_rvalid, out_valid=1, wb_en=1, wb_data=dmem_rdata; FSM returns IDLE.
REQ-019 WAIT timeout counter counts from 0; on reaching TIMEOUT_CYC without rvalid: out_valid=1, wb_en=0, err=1, return IDLE.
REQ-020 dmem_rvalid outside WAIT, or outside the gnt cycle of an LDW in REQ, is ignored.
REQ-021 opcode_out, dest_out and pc_out always carry the fields of the instruction completing on out_valid; they hold their values when out_valid=0.
REQ-022 Without subword support, dmem_be is all ones.

Reset
REQ-023 rst forces state IDLE, timeout count 0, and drives dmem_req, dmem_we, out_valid, wb_en, err to 0; wb_data, dmem_addr, dmem_wdata, opcode_out, dest_out, pc_out are 0; dmem_be is 0.
REQ-024 rst mid-transaction abandons it: no out_valid is produced for it, and a late rvalid after rst is ignored.

Configuration
REQ-025 Macro MEM_SUBWORD_EN defined: opcode LDB/STB/LDH/STH (from the shared opcode header) and byte addressing are enabled; dmem_addr=aluout[DADDR_W+1:2]; dmem_be selects lane(s); store data is replicated across lanes; loads are sign-extended; a misaligned halfword gives out_valid with err=1 and issues no request.
REQ-026 MEM_SUBWORD_EN undefined: subword opcodes execute as NOP (wb_en=0); word addressing only.

Structure
REQ-027 Opcode values and FSM state encodings reside in the shared opcodes header; no literal opcode values appear in this module.
REQ-028 One sub-module, mem_load_align (lane select plus sign extension), is instantiated only under MEM_SUBWORD_EN.

Verification
REQ-029 ADD with aluout=0x0000_0007, dest=3 -> next cycle: out_valid=1, wb_en=1, wb_data=7, dest_out=3.
REQ-030 STR with aluout=0x05, store_data=0xDEAD_BEEF, gnt held low 2 cycles -> dmem_req held for 3 cycles with a stable address; out_valid with wb_en=0 one cycle after gnt.
REQ-031 LDW addr 0x05, gnt and rvalid (rdata=0x1234_5678) in the same cycle -> wb_data=0x1234_5678 in the next cycle; in_ready=1 in that same cycle.
REQ-032 LDW with rvalid never asserted, TIMEOUT_CYC=15 -> err=1, wb_en=0 after 15 WAIT cycles; the next ADD is accepted.
REQ-033 rst asserted in WAIT, then rvalid -> no out_valid; all outputs are 0 after reset.
REQ-034 With MEM_SUBWORD_EN: LDB at byte address 0x13, rdata=0x80FF_0000 -> dmem_be=4'b1000, wb_data=0xFFFF_FF80.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared opcode header for the memory access unit: opcode values, FSM state
// encodings and load size codes used by the subword path.
package mem_access_unit_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_NOT  = 5'd6;
    localparam logic [4:0] OP_LSH  = 5'd7;
    localparam logic [4:0] OP_RSH  = 5'd8;
    localparam logic [4:0] OP_ARSH = 5'd9;
    localparam logic [4:0] OP_LDW  = 5'd10;
    localparam logic [4:0] OP_STR  = 5'd11;
    localparam logic [4:0] OP_LDB  = 5'd12;
    localparam logic [4:0] OP_STB  = 5'd13;
    localparam logic [4:0] OP_LDH  = 5'd14;
    localparam logic [4:0] OP_STH  = 5'd15;

    // Access size of an outstanding load, consumed by the lane aligner.
    localparam logic [1:0] SZ_WORD = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_BYTE = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/mem_load_align.sv
// Lane select and sign extension for subword loads; only present when
// MEM_SUBWORD_EN is defined.
`ifdef MEM_SUBWORD_EN
module mem_load_align
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_off,
    input  logic [1:0]        i_size,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] w_shifted;

    assign w_shifted = i_rdata >> {i_off, 3'b000};

    always_comb begin
        o_data = i_rdata;
        if (i_size == SZ_BYTE) begin
            o_data = {{(DATA_W-8){w_shifted[7]}}, w_shifted[7:0]};
        end else if (i_size == SZ_HALF) begin
            o_data = {{(DATA_W-16){w_shifted[15]}}, w_shifted[15:0]};
        end
    end

endmodule
`endif

// File: rtl/mem_access_unit.sv
// Memory stage: ALU results pass straight to writeback, loads/stores run an
// IDLE/REQ/WAIT handshake. Define MEM_SUBWORD_EN for byte/halfword access.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DADDR_W     = 8,
    parameter int RF_AW       = 4,
    parameter int PC_W        = 5,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4:0]          opcode,
    input  logic                isimm,
    input  logic [DATA_W-1:0]   aluout,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [RF_AW-1:0]    dest_addr,
    input  logic [PC_W-1:0]     pc,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DADDR_W-1:0]  dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    output logic [DATA_W/8-1:0] dmem_be,
    input  logic                dmem_gnt,
    input  logic                dmem_rvalid,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                out_valid,
    output logic                wb_en,
    output logic                err,
    output logic [DATA_W-1:0]   wb_data,
    output logic [4:0]          opcode_out,
    output logic [RF_AW-1:0]    dest_out,
    output logic [PC_W-1:0]     pc_out
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

    state_t             r_state, w_next;
    logic [7:0]         r_cnt;
    logic               r_req, r_we, r_outValid, r_wbEn, r_err;
    logic [DADDR_W-1:0] r_addr;
    logic [DATA_W-1:0]  r_wdata, r_wbData;
    logic [BE_W-1:0]    r_be;
    logic [4:0]         r_op, r_opOut;
    logic [RF_AW-1:0]   r_dest, r_destOut;
    logic [PC_W-1:0]    r_pc, r_pcOut;

    logic               w_accept, w_isAlu, w_aluWb, w_isLoadW, w_isStoreW;
    logic               w_memOp, w_isStore, w_misalign;
    logic [DADDR_W-1:0] w_addr;
    logic [DATA_W-1:0]  w_wdata, w_loadData;
    logic [BE_W-1:0]    w_be;
    logic               w_done, w_doneLoad, w_doneErr;
    logic               w_unused;

`ifdef MEM_SUBWORD_EN
    logic       w_isByte, w_isHalf;
    logic [1:0] w_size, r_size, r_off;

    mem_load_align #(.DATA_W(DATA_W)) u_align (
        .i_rdata (dmem_rdata),
        .i_off   (r_off),
        .i_size  (r_size),
        .o_data  (w_loadData)
    );
`else
    assign w_loadData = dmem_rdata;
`endif

    assign w_unused = ^aluout;
    assign in_ready = (r_state == IDLE) && !rst;
    assign w_accept = in_valid && in_ready;

    // Decode the incoming instruction into a pass-through or a memory request.
    always_comb begin
        w_isLoadW  = !isimm && (opcode == OP_LDW);
        w_isStoreW = !isimm && (opcode == OP_STR);
        w_isAlu    = isimm || (opcode <= OP_ARSH);
        w_aluWb    = w_isAlu && (opcode != OP_NOP);
        w_misalign = 1'b0;
        w_be       = '1;
        w_wdata    = store_data;
`ifdef MEM_SUBWORD_EN
        w_isByte   = !isimm && ((opcode == OP_LDB) || (opcode == OP_STB));
        w_isHalf   = !isimm && ((opcode == OP_LDH) || (opcode == OP_STH));
        w_misalign = w_isHalf && aluout[0];
        w_memOp    = w_isLoadW || w_isStoreW || w_isByte || (w_isHalf && !aluout[0]);
        w_isStore  = w_isStoreW || (!isimm && ((opcode == OP_STB) || (opcode == OP_STH)));
        w_addr     = aluout[DADDR_W+1:2];
        w_size     = SZ_WORD;
        if (w_isByte) begin
            w_size  = SZ_BYTE;
            w_be    = BE_W'(1) << aluout[1:0];
            w_wdata = {BE_W{store_data[7:0]}};
        end else if (w_isHalf) begin
            w_size  = SZ_HALF;
            w_be    = BE_W'(3) << {aluout[1], 1'b0};
            w_wdata = {(DATA_W/16){store_data[15:0]}};
        end
`else
        w_memOp    = w_isLoadW || w_isStoreW;
        w_isStore  = w_isStoreW;
        w_addr     = aluout[DADDR_W-1:0];
`endif
    end

    always_comb begin
        w_next     = r_state;
        w_done     = 1'b0;
        w_doneLoad = 1'b0;
        w_doneErr  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept && w_memOp) begin
                    w_next = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    if (r_we) begin
                        w_next = IDLE;
                        w_done = 1'b1;
                    end else if (dmem_rvalid) begin
                        w_next     = IDLE;
                        w_done     = 1'b1;
                        w_doneLoad = 1'b1;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (dmem_rvalid) begin
                    w_next     = IDLE;
                    w_done     = 1'b1;
                    w_doneLoad = 1'b1;
                end else if (r_cnt == TO_LAST) begin
                    w_next    = IDLE;
                    w_done    = 1'b1;
                    w_doneErr = 1'b1;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Writeback fields are only loaded on completion so they hold between pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_req      <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_be       <= '0;
            r_op       <= '0;
            r_dest     <= '0;
            r_pc       <= '0;
            r_outValid <= 1'b0;
            r_wbEn     <= 1'b0;
            r_err      <= 1'b0;
            r_wbData   <= '0;
            r_opOut    <= '0;
            r_destOut  <= '0;
            r_pcOut    <= '0;
`ifdef MEM_SUBWORD_EN
            r_size     <= SZ_WORD;
            r_off      <= '0;
`endif
        end else begin
            r_state    <= w_next;
            r_outValid <= 1'b0;
            r_wbEn     <= 1'b0;
            r_err      <= 1'b0;
            if (r_state == IDLE && w_accept) begin
                if (w_memOp) begin
                    r_req   <= 1'b1;
                    r_we    <= w_isStore;
                    r_addr  <= w_addr;
                    r_wdata <= w_wdata;
                    r_be    <= w_be;
                    r_op    <= opcode;
                    r_dest  <= dest_addr;
                    r_pc    <= pc;
`ifdef MEM_SUBWORD_EN
                    r_size  <= w_size;
                    r_off   <= aluout[1:0];
`endif
                end else begin
                    r_outValid <= 1'b1;
                    r_wbEn     <= w_aluWb;
                    r_err      <= w_misalign;
                    r_wbData   <= aluout;
                    r_opOut    <= opcode;
                    r_destOut  <= dest_addr;
                    r_pcOut    <= pc;
                end
            end
            if (r_state == REQ && dmem_gnt) begin
                r_req <= 1'b0;
                r_we  <= 1'b0;
                r_cnt <= '0;
            end
            if (r_state == WAIT) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_done) begin
                r_outValid <= 1'b1;
                r_wbEn     <= w_doneLoad;
                r_err      <= w_doneErr;
                r_opOut    <= r_op;
                r_destOut  <= r_dest;
                r_pcOut    <= r_pc;
                if (w_doneLoad) begin
                    r_wbData <= w_loadData;
                end
            end
        end
    end

    assign dmem_req   = r_req;
    assign dmem_we    = r_we;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign dmem_be    = r_be;
    assign out_valid  = r_outValid;
    assign wb_en      = r_wbEn;
    assign err        = r_err;
    assign wb_data    = r_wbData;
    assign opcode_out = r_opOut;
    assign dest_out   = r_destOut;
    assign pc_out     = r_pcOut;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit in the default build
// (MEM_SUBWORD_EN undefined): pass-through, store, load, timeout and reset abort.
module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  opcode;
    logic        isimm;
    logic [31:0] aluout;
    logic [31:0] store_data;
    logic [3:0]  dest_addr;
    logic [4:0]  pc;
    logic        dmem_req;
    logic        dmem_we;
    logic [7:0]  dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        out_valid;
    logic        wb_en;
    logic        err;
    logic [31:0] wb_data;
    logic [4:0]  opcode_out;
    logic [3:0]  dest_out;
    logic [4:0]  pc_out;

    int total = 0;
    int bad   = 0;
    int pulses;

    mem_access_unit #(
        .DATA_W(32), .DADDR_W(8), .RF_AW(4), .PC_W(5), .TIMEOUT_CYC(15)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .isimm(isimm), .aluout(aluout), .store_data(store_data),
        .dest_addr(dest_addr), .pc(pc),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_gnt(dmem_gnt),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .out_valid(out_valid), .wb_en(wb_en), .err(err), .wb_data(wb_data),
        .opcode_out(opcode_out), .dest_out(dest_out), .pc_out(pc_out)
    );

    always #5 clk = ~clk;

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [4:0] op, input logic imm, input logic [31:0] alu,
                                 input logic [31:0] sd, input logic [3:0] dst, input logic [4:0] p);
        opcode     = op;
        isimm      = imm;
        aluout     = alu;
        store_data = sd;
        dest_addr  = dst;
        pc         = p;
        in_valid   = 1'b1;
        tick();
        in_valid   = 1'b0;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; opcode = '0; isimm = 1'b0; aluout = '0;
        store_data = '0; dest_addr = '0; pc = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        tick();
        tick();
        checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_wb_data", wb_data, 32'd0);
        checkOutput("rst_req", 32'(dmem_req), 32'd0);
        checkOutput("rst_be", 32'(dmem_be), 32'd0);
        rst = 1'b0;
        #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        $display("[TB] ALU pass-through");
        applyStimulus(OP_ADD, 1'b0, 32'h0000_0007, 32'h0, 4'd3, 5'd1);
        checkOutput("add_valid", 32'(out_valid), 32'd1);
        checkOutput("add_wb_en", 32'(wb_en), 32'd1);
        checkOutput("add_wb_data", wb_data, 32'd7);
        checkOutput("add_dest", 32'(dest_out), 32'd3);
        checkOutput("add_pc", 32'(pc_out), 32'd1);
        checkOutput("add_op", 32'(opcode_out), 32'(OP_ADD));
        tick();
        checkOutput("add_pulse_end", 32'(out_valid), 32'd0);
        checkOutput("add_dest_hold", 32'(dest_out), 32'd3);

        applyStimulus(OP_NOP, 1'b0, 32'h0000_0099, 32'h0, 4'd4, 5'd2);
        checkOutput("nop_valid", 32'(out_valid), 32'd1);
        checkOutput("nop_wb_en", 32'(wb_en), 32'd0);

        applyStimulus(OP_LDW, 1'b1, 32'h0000_0042, 32'h0, 4'd5, 5'd3);
        checkOutput("imm_valid", 32'(out_valid), 32'd1);
        checkOutput("imm_wb_en", 32'(wb_en), 32'd1);
        checkOutput("imm_wb_data", wb_data, 32'h42);
        checkOutput("imm_no_req", 32'(dmem_req), 32'd0);

        applyStimulus(OP_LDB, 1'b0, 32'h0000_0013, 32'h0, 4'd6, 5'd4);
        checkOutput("ldb_nop_valid", 32'(out_valid), 32'd1);
        checkOutput("ldb_nop_wb_en", 32'(wb_en), 32'd0);
        checkOutput("ldb_nop_req", 32'(dmem_req), 32'd0);

        $display("[TB] store with delayed grant");
        applyStimulus(OP_STR, 1'b0, 32'h0000_0005, 32'hDEAD_BEEF, 4'd7, 5'd5);
        checkOutput("str_req_c1", 32'(dmem_req), 32'd1);
        checkOutput("str_we", 32'(dmem_we), 32'd1);
        checkOutput("str_addr_c1", 32'(dmem_addr), 32'h05);
        checkOutput("str_wdata", dmem_wdata, 32'hDEAD_BEEF);
        checkOutput("str_be", 32'(dmem_be), 32'hF);
        checkOutput("str_busy", 32'(in_ready), 32'd0);
        tick();
        checkOutput("str_req_c2", 32'(dmem_req), 32'd1);
        tick();
        checkOutput("str_req_c3", 32'(dmem_req), 32'd1);
        checkOutput("str_addr_c3", 32'(dmem_addr), 32'h05);
        checkOutput("str_no_early_valid", 32'(out_valid), 32'd0);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        checkOutput("str_req_drop", 32'(dmem_req), 32'd0);
        checkOutput("str_valid", 32'(out_valid), 32'd1);
        checkOutput("str_wb_en", 32'(wb_en), 32'd0);
        checkOutput("str_dest", 32'(dest_out), 32'd7);

        $display("[TB] load with rvalid in grant cycle");
        applyStimulus(OP_LDW, 1'b0, 32'h0000_0005, 32'h0, 4'd8, 5'd6);
        checkOutput("ldw_req", 32'(dmem_req), 32'd1);
        checkOutput("ldw_we", 32'(dmem_we), 32'd0);
        dmem_gnt = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        tick();
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
        checkOutput("ldw_fast_valid", 32'(out_valid), 32'd1);
        checkOutput("ldw_fast_data", wb_data, 32'h1234_5678);
        checkOutput("ldw_fast_wb_en", 32'(wb_en), 32'd1);
        checkOutput("ldw_fast_ready", 32'(in_ready), 32'd1);
        checkOutput("ldw_fast_pc", 32'(pc_out), 32'd6);

        $display("[TB] load through WAIT");
        applyStimulus(OP_LDW, 1'b0, 32'h0000_0020, 32'h0, 4'd9, 5'd7);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        checkOutput("wait_no_valid", 32'(pulses), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hA5A5_0001;
        tick();
        dmem_rvalid = 1'b0;
        checkOutput("wait_valid", 32'(out_valid), 32'd1);
        checkOutput("wait_data", wb_data, 32'hA5A5_0001);
        checkOutput("wait_dest", 32'(dest_out), 32'd9);

        $display("[TB] load timeout");
        applyStimulus(OP_LDW, 1'b0, 32'h0000_0030, 32'h0, 4'd10, 5'd8);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (out_valid) pulses++;
        end
        checkOutput("to_no_early", 32'(pulses), 32'd0);
        tick();
        checkOutput("to_valid", 32'(out_valid), 32'd1);
        checkOutput("to_err", 32'(err), 32'd1);
        checkOutput("to_wb_en", 32'(wb_en), 32'd0);
        checkOutput("to_ready", 32'(in_ready), 32'd1);
        applyStimulus(OP_ADD, 1'b0, 32'h0000_0011, 32'h0, 4'd2, 5'd9);
        checkOutput("to_next_valid", 32'(out_valid), 32'd1);
        checkOutput("to_next_data", wb_data, 32'h11);
        checkOutput("to_next_err", 32'(err), 32'd0);

        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        tick();
        dmem_rvalid = 1'b0;
        checkOutput("stray_rvalid", 32'(out_valid), 32'd0);

        $display("[TB] reset while waiting");
        applyStimulus(OP_LDW, 1'b0, 32'h0000_0040, 32'h0, 4'd11, 5'd10);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        dmem_rvalid = 1'b1; dmem_rdata = 32'h5555_AAAA;
        tick();
        dmem_rvalid = 1'b0;
        checkOutput("rstw_no_valid", 32'(out_valid), 32'd0);
        checkOutput("rstw_wb_data", wb_data, 32'd0);
        checkOutput("rstw_dest", 32'(dest_out), 32'd0);
        checkOutput("rstw_req", 32'(dmem_req), 32'd0);
        checkOutput("rstw_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
